// File: rtl/macplus_kbd_proto.sv
// -----------------------------------------------------------------------------
// macplus_kbd_proto
// Macintosh Plus keyboard protocol engine. Translated key events are encoded
// into Mac keyboard byte sequences and queued in a byte FIFO; host command
// bytes (Inquiry, Instant, Model, Test) are answered with single reply bytes.
//
// Ports
//   clk         single clock, rising edge
//   reset_n     synchronous active-low reset
//   key_valid   one-cycle key event strobe
//   key_mac     [8:7] class, [6:0] code
//   key_break   1 = release, 0 = press (sampled with key_valid)
//   cmd_valid   one-cycle host command strobe
//   cmd         host command byte
//   resp_valid  one-cycle reply strobe
//   resp        reply byte (0x00 when resp_valid is low)
//   busy        command accepted and reply not yet issued
//   overrun     sticky: a key event was dropped
// -----------------------------------------------------------------------------
module macplus_kbd_proto #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned INQ_TIMEOUT = 8000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [8:0] key_mac,
  input  logic       key_break,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  output logic       resp_valid,
  output logic [7:0] resp,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_W = (INQ_TIMEOUT > 1) ? $clog2(INQ_TIMEOUT) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((INQ_TIMEOUT > 0) ? (INQ_TIMEOUT - 1) : 0);

  localparam logic [7:0] CMD_INQUIRY = 8'h10;
  localparam logic [7:0] CMD_INSTANT = 8'h14;
  localparam logic [7:0] CMD_MODEL   = 8'h16;
  localparam logic [7:0] CMD_TEST    = 8'h36;

  localparam logic [7:0] RSP_NULL    = 8'h7B;
  localparam logic [7:0] RSP_MODEL   = 8'h0B;
  localparam logic [7:0] RSP_TEST    = 8'h7D;
  localparam logic [7:0] RSP_UNKNOWN = 8'h77;

  typedef struct packed {
    logic [8:0] mac;
    logic       brk;
  } key_ev_t;

  typedef struct packed {
    logic [1:0] len;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } key_seq_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INQ_WAIT,
    ST_REPLY
  } state_t;

  // Byte sequence for one (already filtered) key event.
  function automatic key_seq_t encode(input key_ev_t ev);
    key_seq_t   s;
    logic [7:0] c;
    logic [7:0] b;
    c = {1'b0, ev.mac[6:0]};
    b = ev.brk ? 8'h80 : 8'h00;
    s = '0;
    case (ev.mac[8:7])
      2'd0: begin
        s.len = 2'd1;
        s.b0  = c | b;
      end
      2'd1: begin
        s.len = 2'd2;
        s.b0  = 8'h79;
        s.b1  = c | b;
      end
      default: begin
        s.len = 2'd3;
        s.b0  = ev.brk ? 8'hF1 : 8'h71;
        s.b1  = 8'h79;
        s.b2  = c | b;
      end
    endcase
    return s;
  endfunction

  // FIFO storage and pointers
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty_c;
  logic [7:0]       head_c;

  // Enqueue engine state
  logic             hold_valid, hold_valid_nxt;
  key_ev_t          hold_ev, hold_ev_nxt;
  logic [1:0]       seq_rem, seq_rem_nxt;
  logic [7:0]       seq_b1, seq_b1_nxt;
  logic [7:0]       seq_b2, seq_b2_nxt;

  key_ev_t          in_ev_c;
  logic             in_ok_c;
  key_ev_t          src_ev_c;
  logic             src_valid_c;
  key_seq_t         src_seq_c;
  logic [CNT_W-1:0] free_c;
  logic             wr_en_c;
  logic [7:0]       wr_data_c;
  logic             drop_c;

  // Command FSM state
  state_t           state, state_nxt;
  logic [7:0]       cmd_q, cmd_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             resp_valid_nxt;
  logic [7:0]       resp_nxt;
  logic             busy_nxt;
  logic             pop_c;
  logic             flush_c;

  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];

  // Incoming event after discarding class 2 and the 0x7F "no key" code
  assign in_ev_c = '{mac: key_mac, brk: key_break};
  assign in_ok_c = key_valid && (key_mac[8:7] != 2'd2) && (key_mac[6:0] != 7'h7F);

  // A held event has priority over a new one when the engine is free
  assign src_ev_c    = hold_valid ? hold_ev : in_ev_c;
  assign src_valid_c = hold_valid || in_ok_c;
  assign src_seq_c   = encode(src_ev_c);

  // A same-cycle pop frees a slot for the byte written in this cycle
  assign free_c = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop_c);

  // Enqueue engine: one byte per cycle, space reserved for the whole sequence
  always_comb begin
    wr_en_c        = 1'b0;
    wr_data_c      = seq_b1;
    drop_c         = 1'b0;
    seq_rem_nxt    = seq_rem;
    seq_b1_nxt     = seq_b1;
    seq_b2_nxt     = seq_b2;
    hold_valid_nxt = hold_valid;
    hold_ev_nxt    = hold_ev;

    if (seq_rem != 2'd0) begin
      wr_en_c     = 1'b1;
      wr_data_c   = seq_b1;
      seq_b1_nxt  = seq_b2;
      seq_rem_nxt = seq_rem - 2'd1;
      if (in_ok_c) begin
        if (hold_valid) begin
          drop_c = 1'b1;
        end else begin
          hold_valid_nxt = 1'b1;
          hold_ev_nxt    = in_ev_c;
        end
      end
    end else if (src_valid_c) begin
      if (CNT_W'(src_seq_c.len) > free_c) begin
        drop_c = 1'b1;
      end else begin
        wr_en_c     = 1'b1;
        wr_data_c   = src_seq_c.b0;
        seq_b1_nxt  = src_seq_c.b1;
        seq_b2_nxt  = src_seq_c.b2;
        seq_rem_nxt = src_seq_c.len - 2'd1;
      end
      // Holding register consumed; a same-cycle new event takes its place
      if (hold_valid) begin
        hold_valid_nxt = in_ok_c;
        hold_ev_nxt    = in_ev_c;
      end
    end
  end

  // Enqueue engine registers and sticky overrun
  always_ff @(posedge clk) begin
    if (!reset_n || flush_c) begin
      hold_valid <= 1'b0;
      hold_ev    <= '0;
      seq_rem    <= 2'd0;
      seq_b1     <= 8'h00;
      seq_b2     <= 8'h00;
    end else begin
      hold_valid <= hold_valid_nxt;
      hold_ev    <= hold_ev_nxt;
      seq_rem    <= seq_rem_nxt;
      seq_b1     <= seq_b1_nxt;
      seq_b2     <= seq_b2_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush_c) begin
      overrun <= 1'b0;
    end else if (drop_c) begin
      overrun <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n || flush_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO data; when full, a write and pop share a slot and the pop reads old data
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= wr_data_c;
    end
  end

  // Command FSM: next state, next outputs, pop/flush strobes
  always_comb begin
    state_nxt      = state;
    cmd_nxt        = cmd_q;
    timer_nxt      = timer;
    resp_valid_nxt = 1'b0;
    resp_nxt       = 8'h00;
    busy_nxt       = busy;
    pop_c          = 1'b0;
    flush_c        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_nxt   = cmd;
          busy_nxt  = 1'b1;
          state_nxt = ST_REPLY;
        end
      end

      ST_REPLY: begin
        resp_valid_nxt = 1'b1;
        busy_nxt       = 1'b0;
        state_nxt      = ST_IDLE;
        case (cmd_q)
          CMD_INQUIRY: begin
            if (!empty_c) begin
              pop_c    = 1'b1;
              resp_nxt = head_c;
            end else begin
              resp_valid_nxt = 1'b0;
              busy_nxt       = 1'b1;
              timer_nxt      = '0;
              state_nxt      = ST_INQ_WAIT;
            end
          end
          CMD_INSTANT: begin
            if (!empty_c) begin
              pop_c    = 1'b1;
              resp_nxt = head_c;
            end else begin
              resp_nxt = RSP_NULL;
            end
          end
          CMD_MODEL: begin
            flush_c  = 1'b1;
            resp_nxt = RSP_MODEL;
          end
          CMD_TEST: resp_nxt = RSP_TEST;
          default:  resp_nxt = RSP_UNKNOWN;
        endcase
      end

      ST_INQ_WAIT: begin
        if (!empty_c) begin
          pop_c          = 1'b1;
          resp_nxt       = head_c;
          resp_valid_nxt = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = ST_IDLE;
        end else if (timer == TMR_LAST) begin
          resp_nxt       = RSP_NULL;
          resp_valid_nxt = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = ST_IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Command FSM state register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cmd_q      <= 8'h00;
      timer      <= '0;
      resp_valid <= 1'b0;
      resp       <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cmd_q      <= cmd_nxt;
      timer      <= timer_nxt;
      resp_valid <= resp_valid_nxt;
      resp       <= resp_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_macplus_kbd_proto.sv
// -----------------------------------------------------------------------------
// tb_macplus_kbd_proto
// Self-checking bench. Two instances (depth 8 and depth 4, both with a
// 100-cycle inquiry timeout) share the stimulus signals; `sel` routes the
// strobes and outputs. Expected bytes come from a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_macplus_kbd_proto;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [8:0] key_mac;
  logic       key_break;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       sel;

  logic       rv_a, busy_a, ovr_a;
  logic [7:0] resp_a;
  logic       rv_b, busy_b, ovr_b;
  logic [7:0] resp_b;

  logic       resp_valid, busy, overrun;
  logic [7:0] resp;

  always #5 clk = ~clk;

  assign resp_valid = sel ? rv_b   : rv_a;
  assign resp       = sel ? resp_b : resp_a;
  assign busy       = sel ? busy_b : busy_a;
  assign overrun    = sel ? ovr_b  : ovr_a;

  macplus_kbd_proto #(.FIFO_DEPTH(8), .INQ_TIMEOUT(100)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_valid  (key_valid & ~sel),
    .key_mac    (key_mac),
    .key_break  (key_break),
    .cmd_valid  (cmd_valid & ~sel),
    .cmd        (cmd),
    .resp_valid (rv_a),
    .resp       (resp_a),
    .busy       (busy_a),
    .overrun    (ovr_a)
  );

  macplus_kbd_proto #(.FIFO_DEPTH(4), .INQ_TIMEOUT(100)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_valid  (key_valid & sel),
    .key_mac    (key_mac),
    .key_break  (key_break),
    .cmd_valid  (cmd_valid & sel),
    .cmd        (cmd),
    .resp_valid (rv_b),
    .resp       (resp_b),
    .busy       (busy_b),
    .overrun    (ovr_b)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mq[$];
  bit         m_ovr;
  int         depth;
  logic [7:0] last_resp;
  int         last_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a key event appends its whole byte sequence or nothing
  task automatic model_key(input logic [8:0] mac, input bit brk);
    logic [7:0] c;
    logic [7:0] b;
    logic [7:0] seq[$];
    c = {1'b0, mac[6:0]};
    b = brk ? 8'h80 : 8'h00;
    if (mac[8:7] == 2'd2 || mac[6:0] == 7'h7F) return;
    if (mac[8:7] == 2'd0) begin
      seq.push_back(c | b);
    end else if (mac[8:7] == 2'd1) begin
      seq.push_back(8'h79);
      seq.push_back(c | b);
    end else if (brk) begin
      seq.push_back(8'hF1);
      seq.push_back(8'h79);
      seq.push_back(c | 8'h80);
    end else begin
      seq.push_back(8'h71);
      seq.push_back(8'h79);
      seq.push_back(c);
    end
    if (mq.size() + seq.size() > depth) m_ovr = 1'b1;
    else foreach (seq[i]) mq.push_back(seq[i]);
  endtask

  // Reference model: reply byte and latency (cycles after cmd_valid)
  task automatic model_cmd(input logic [7:0] c, output logic [7:0] r, output int lat);
    lat = 2;
    case (c)
      8'h10: begin
        if (mq.size() > 0) r = mq.pop_front();
        else begin
          r   = 8'h7B;
          lat = 100 + 2;
        end
      end
      8'h14: begin
        if (mq.size() > 0) r = mq.pop_front();
        else r = 8'h7B;
      end
      8'h16: begin
        mq.delete();
        m_ovr = 1'b0;
        r     = 8'h0B;
      end
      8'h36:   r = 8'h7D;
      default: r = 8'h77;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    key_valid = 1'b0;
    cmd_valid = 1'b0;
    tick(2);
    reset_n = 1'b1;
    mq.delete();
    m_ovr = 1'b0;
    depth = sel ? 4 : 8;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp",       32'(resp),       32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
  endtask

  task automatic press(input logic [8:0] mac, input bit brk);
    @(negedge clk);
    key_valid = 1'b1;
    key_mac   = mac;
    key_break = brk;
    @(negedge clk);
    key_valid = 1'b0;
    model_key(mac, brk);
    tick(3);
  endtask

  // Issue a command; optionally inject a press at cycle key_at (cmd cycle = 0)
  task automatic run_cmd(input logic [7:0] c, input int key_at, input logic [8:0] kmac);
    bit got;
    bit busy_ok;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    last_lat  = 0;
    got       = 1'b0;
    busy_ok   = 1'b1;
    while (!got && last_lat < 300) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      last_lat++;
      if (resp_valid === 1'b1) begin
        got       = 1'b1;
        last_resp = resp;
        check($sformatf("busy_at_resp_%02h", c), 32'(busy), 32'd0);
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      key_valid = (last_lat == key_at);
      key_mac   = kmac;
      key_break = 1'b0;
    end
    key_valid = 1'b0;
    check($sformatf("resp_seen_%02h", c), 32'(got), 32'd1);
    check($sformatf("busy_held_%02h", c), 32'(busy_ok), 32'd1);
  endtask

  task automatic cmd_step(input logic [7:0] c, input int key_at, input logic [8:0] kmac);
    logic [7:0] er;
    int         el;
    model_cmd(c, er, el);
    if (key_at > 0) model_key(kmac, 1'b0);
    run_cmd(c, key_at, kmac);
    check($sformatf("resp_%02h", c),    32'(last_resp), 32'(er));
    check($sformatf("latency_%02h", c), 32'(last_lat),  32'(el));
    check($sformatf("ovr_after_%02h", c), 32'(overrun), 32'(m_ovr));
  endtask

  task automatic random_phase(input int steps);
    logic [8:0] m;
    logic [7:0] c;
    int         r;
    for (int s = 0; s < steps; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        m = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 7) == 0) m[6:0] = 7'h7F;
        press(m, 1'($urandom_range(0, 1)));
        check("rand_ovr", 32'(overrun), 32'(m_ovr));
      end else begin
        r = $urandom_range(0, 9);
        if (r < 4)       c = 8'h10;
        else if (r < 7)  c = 8'h14;
        else if (r == 7) c = 8'h16;
        else if (r == 8) c = 8'h36;
        else             c = 8'($urandom_range(0, 255));
        cmd_step(c, 0, 9'h000);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit spurious;
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_mac   = 9'h000;
    key_break = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 8'h00;
    sel       = 1'b0;

    // ---------------- depth-8 instance ----------------
    do_reset();

    // 'a' pressed, Inquiry then Instant
    press(9'h001, 1'b0);
    cmd_step(8'h10, 0, 9'h000);
    check("a_inquiry", 32'(last_resp), 32'h01);
    cmd_step(8'h14, 0, 9'h000);
    check("a_instant_empty", 32'(last_resp), 32'h7B);

    // Shift make/break, six Inquiries
    press(9'h191, 1'b0);
    press(9'h191, 1'b1);
    for (int i = 0; i < 6; i++) cmd_step(8'h10, 0, 9'h000);
    check("shift_last", 32'(last_resp), 32'h91);

    // Inquiry timeout on empty FIFO
    cmd_step(8'h10, 0, 9'h000);
    check("inq_timeout_lat", 32'(last_lat), 32'd102);

    // Inquiry hit while waiting
    run_cmd(8'h10, 20, 9'h025);
    check("inq_wait_resp", 32'(last_resp), 32'h25);
    check("inq_wait_lat",  32'(last_lat),  32'd22);

    // Class 1 and discarded events
    press(9'h0C2, 1'b1);
    press(9'h17F, 1'b0);
    press(9'h105, 1'b0);
    cmd_step(8'h14, 0, 9'h000);
    check("class1_prefix", 32'(last_resp), 32'h79);
    cmd_step(8'h14, 0, 9'h000);
    check("class1_code", 32'(last_resp), 32'hC2);
    cmd_step(8'h14, 0, 9'h000);
    cmd_step(8'h36, 0, 9'h000);
    cmd_step(8'h55, 0, 9'h000);

    // Back-to-back events: second waits in the holding register
    @(negedge clk); key_valid = 1'b1; key_mac = 9'h1A2; key_break = 1'b0;
    @(negedge clk); key_mac = 9'h005;
    @(negedge clk); key_valid = 1'b0;
    tick(5);
    model_key(9'h1A2, 1'b0);
    model_key(9'h005, 1'b0);
    check("hold_no_ovr", 32'(overrun), 32'(m_ovr));
    for (int i = 0; i < 5; i++) cmd_step(8'h14, 0, 9'h000);

    // Third event while holding register is full is dropped
    @(negedge clk); key_valid = 1'b1; key_mac = 9'h1A2; key_break = 1'b0;
    @(negedge clk); key_mac = 9'h005;
    @(negedge clk); key_mac = 9'h0B3;
    @(negedge clk); key_valid = 1'b0;
    tick(5);
    model_key(9'h1A2, 1'b0);
    model_key(9'h005, 1'b0);
    m_ovr = 1'b1;
    check("hold_full_ovr", 32'(overrun), 32'd1);
    for (int i = 0; i < 5; i++) cmd_step(8'h14, 0, 9'h000);

    // Reset during INQ_WAIT abandons the command
    do_reset();
    @(negedge clk); cmd_valid = 1'b1; cmd = 8'h10;
    @(negedge clk); cmd_valid = 1'b0;
    tick(10);
    check("wait_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_busy",       32'(busy),       32'd0);
    spurious = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) spurious = 1'b1;
    end
    check("abort_no_reply", 32'(spurious), 32'd0);
    mq.delete();
    m_ovr = 1'b0;
    cmd_step(8'h36, 0, 9'h000);
    check("test_after_abort", 32'(last_resp), 32'h7D);

    random_phase(80);

    // ---------------- depth-4 instance ----------------
    sel = 1'b1;
    do_reset();
    for (int i = 1; i <= 5; i++) press(9'(i), 1'b0);
    check("d4_overrun", 32'(overrun), 32'd1);
    cmd_step(8'h16, 0, 9'h000);
    check("d4_model",   32'(last_resp), 32'h0B);
    check("d4_ovr_clr", 32'(overrun),   32'd0);
    cmd_step(8'h14, 0, 9'h000);
    check("d4_flushed", 32'(last_resp), 32'h7B);

    // Pop and write in the same cycle on a full FIFO
    for (int i = 1; i <= 4; i++) press(9'(i), 1'b0);
    cmd_step(8'h14, 1, 9'h009);
    for (int i = 0; i < 5; i++) cmd_step(8'h14, 0, 9'h000);
    check("d4_pop_write_tail", 32'(last_resp), 32'h7B);

    random_phase(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/macplus_kbd_proto.md
MACPLUS_KBD_PROTO -- requirements
Module: macplus_kbd_proto

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 16: byte FIFO depth, power of two, minimum 4.
REQ-002 SHALL provide parameter INQ_TIMEOUT, default 8000000: clock cycles an Inquiry waits before a NULL reply (0.25 s at 32 MHz).
REQ-003 SHALL provide port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL provide port key_valid, input, 1: one-cycle strobe marking a key event.
REQ-006 SHALL provide port key_mac, input, 9: translated key code; [8:7] is the class, [6:0] is the code.
REQ-007 SHALL provide port key_break, input, 1: 1 = key release, 0 = key press; sampled with key_valid.
REQ-008 SHALL provide port cmd_valid, input, 1: one-cycle strobe carrying a host command byte.
REQ-009 SHALL provide port cmd, input, 8: the host command byte.
REQ-010 SHALL provide port resp_valid, output, 1: one-cycle strobe marking a reply byte.
REQ-011 SHALL provide port resp, output, 8: the reply byte, valid only while resp_valid = 1.
REQ-012 SHALL provide port busy, output, 1: high while a command is pending or its reply has not been issued.
REQ-013 SHALL provide port overrun, output, 1: sticky flag set when a key event was dropped.

Function
REQ-014 Event encoding, with c = key_mac[6:0] and b = 0x80 when key_break = 1 (else 0x00):
- class 0 -> one byte: c|b.
- class 1 -> 0x79, then c|b.
- class 3 -> make: 0x71, 0x79, c; break: 0xF1, 0x79, c|0x80.
REQ-015 An event with c = 0x7F, or with class 2, SHALL be discarded without effect.
REQ-016 An event's bytes SHALL be written atomically, all or none, in the order given by REQ-014.
- If free space is less than the sequence length, the event SHALL be dropped and overrun set.
REQ-017 Enqueue SHALL take one cycle per byte.
- Events arriving while a multi-byte enqueue is in progress SHALL be held in a one-entry holding register.
- An event arriving while the holding register is full SHALL be dropped and overrun set.
REQ-018 Command FSM states: IDLE, INQ_WAIT, REPLY.
- In IDLE, a cmd_valid SHALL latch cmd and raise busy on the next cycle.
- cmd_valid while busy = 1 SHALL be ignored.
REQ-019 Inquiry 0x10:
- FIFO non-empty -> pop the head byte and reply with it.
- FIFO empty -> enter INQ_WAIT.
- In INQ_WAIT, the first byte to arrive SHALL be popped and replied.
- After INQ_TIMEOUT cycles with no byte, reply 0x7B.
REQ-020 Instant 0x14 SHALL pop and reply the head byte, or reply 0x7B if the FIFO is empty; it SHALL NOT wait.
REQ-021 Model 0x16 SHALL flush the FIFO and holding register, clear overrun, and reply 0x0B.
REQ-022 Test 0x36 SHALL reply 0x7D.
REQ-023 Any other command SHALL reply 0x77.
REQ-024 Reply latency:
- Non-waiting commands SHALL assert resp_valid exactly 2 cycles after the cmd_valid cycle.
- An INQ_WAIT hit SHALL reply 1 cycle after the byte becomes readable.
- busy SHALL fall in the same cycle resp_valid is high.
REQ-025 A pop and an enqueue write in the same cycle SHALL both take effect; count stays consistent; no spurious overrun.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full = count equals FIFO_DEPTH, empty = count equals 0.
REQ-027 overrun SHALL clear only on reset or a Model command.

Reset
REQ-028 On reset_n = 0 at a clock edge, the block SHALL:
- empty the FIFO, clear the holding register and timer, and enter IDLE;
- drive resp_valid = 0, resp = 0x00, busy = 0, overrun = 0;
- abandon any mid-operation command without a reply.

Verification
REQ-029 Press 'a' (key_mac 0x001), then Inquiry -> resp 0x01 at cmd+2 cycles; a second Instant -> 0x7B.
REQ-030 Shift-down event (class 3, c = 0x11) make then break, then 6 Inquiries -> 0x71, 0x79, 0x11, 0xF1, 0x79, 0x91.
REQ-031 Inquiry on an empty FIFO with INQ_TIMEOUT = 100, no keys -> 0x7B at cmd+102; busy high throughout.
REQ-032 Inquiry on an empty FIFO, key 0x025 pressed 20 cycles later -> reply 0x25 before the timeout.
REQ-033 FIFO_DEPTH = 4, five class-0 presses -> fifth dropped and overrun = 1; then Model -> 0x0B, overrun = 0, Instant -> 0x7B.
REQ-034 reset_n low during INQ_WAIT -> no resp_valid, busy = 0 next cycle; Test afterwards -> 0x7D.
